mercury2_dac_sequencer: RTL and testbench

MERCURY2_DAC_SEQUENCER -- requirements
Module: mercury2_dac_sequencer

---
 rtl/mercury2_dac_pkg.sv | 36 +++
 rtl/dac_spi_shifter.sv | 87 ++++++++
 rtl/mercury2_dac_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_mercury2_dac_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mercury2_dac_pkg.sv
// Shared types and constants for the Mercury2 DAC sequencer: FSM encodings, the
// frame header and the settling-delay calculation.
package mercury2_dac_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StGap,
        StLdac,
        StSettle
    } seq_state_e;

    typedef enum logic [1:0] {
        SpIdle,
        SpLoad,
        SpShift,
        SpTail
    } spi_state_e;

    // Frame bits 14..12, sitting between the channel bit and the 12-bit code.
    localparam logic [2:0] FrameHdr = 3'b011;

    // ceil(freq * t), tolerant of the float error in values like 4.5e-6.
    function automatic int unsigned delay_clocks(input int unsigned freq, input real t);
        real         prod;
        int unsigned n;
        prod = real'(freq) * t;
        n    = $rtoi(prod);
        if (real'(n) < prod - 1.0e-6) begin
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// Serialises one 16-bit DAC frame MSB first: one load cycle, then per bit sck low
// for SckHalf cycles and high for SckHalf cycles; done marks the cycle before csn rises.
module dac_spi_shifter
    import mercury2_dac_pkg::*;
#(
    parameter int unsigned SckHalf = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_frame,
    output logic        o_done,
    output logic        o_csn,
    output logic        o_sck,
    output logic        o_sdi
);

    localparam int unsigned     HalfW    = (SckHalf > 1) ? $clog2(SckHalf) : 1;
    localparam logic [HalfW-1:0] HalfLast = HalfW'(SckHalf - 1);

    spi_state_e       r_state;
    logic [15:0]      r_shreg;
    logic [3:0]       r_bit;
    logic [HalfW-1:0] r_cnt;
    logic             r_csn;
    logic             r_sck;
    logic             r_sdi;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SpIdle;
            r_shreg <= '0;
            r_bit   <= '0;
            r_cnt   <= '0;
            r_csn   <= 1'b1;
            r_sck   <= 1'b0;
            r_sdi   <= 1'b0;
        end else begin
            unique case (r_state)
                SpIdle: begin
                    if (i_start) begin
                        r_shreg <= i_frame;
                        r_csn   <= 1'b0;
                        r_sdi   <= i_frame[15];
                        r_sck   <= 1'b0;
                        r_bit   <= '0;
                        r_cnt   <= '0;
                        r_state <= SpLoad;
                    end
                end
                SpLoad: r_state <= SpShift;
                SpShift: begin
                    if (r_cnt == HalfLast) begin
                        r_cnt <= '0;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                        end else begin
                            // Falling edge: next data bit goes out while sck is low.
                            r_sck <= 1'b0;
                            if (r_bit == 4'd15) begin
                                r_state <= SpTail;
                            end else begin
                                r_bit   <= r_bit + 4'd1;
                                r_shreg <= {r_shreg[14:0], 1'b0};
                                r_sdi   <= r_shreg[14];
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SpTail: begin
                    r_csn   <= 1'b1;
                    r_sdi   <= 1'b0;
                    r_state <= SpIdle;
                end
                default: r_state <= SpIdle;
            endcase
        end
    end

    assign o_done = (r_state == SpTail);
    assign o_csn  = r_csn;
    assign o_sck  = r_sck;
    assign o_sdi  = r_sdi;

endmodule

// File: rtl/mercury2_dac_sequencer.sv
// Multi-channel serial DAC sequencer: shadow/pending registers per channel, round-robin
// dispatch to the SPI shifter, then LDAC pulse and analog settling wait.
module mercury2_dac_sequencer
    import mercury2_dac_pkg::*;
#(
    parameter int unsigned ClockFreq    = 50_000_000,
    parameter real         SettlingTime = 4.5e-6,
    parameter int unsigned NumChannels  = 2,
    parameter int unsigned DataWidth    = 10,
    parameter int unsigned SckHalf      = 2,
    localparam int unsigned ChanW       = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                 clk_50MHZ,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [ChanW-1:0]     wr_chan,
    input  logic [DataWidth-1:0] wr_data,
    input  logic                 sync_mode,
    output logic                 busy,
    output logic                 settled,
    output logic                 wr_err,
    output logic                 dac_csn,
    output logic                 dac_sdi,
    output logic                 dac_ldac,
    output logic                 dac_sck
);

    localparam int unsigned       DelayClocks = delay_clocks(ClockFreq, SettlingTime);
    localparam int unsigned       SettleW     = (DelayClocks > 0) ? $clog2(DelayClocks + 1) : 1;
    localparam logic [SettleW-1:0] SettleLast =
        SettleW'((DelayClocks > 0) ? DelayClocks - 1 : 0);
    localparam int unsigned       HalfW       = (SckHalf > 1) ? $clog2(SckHalf) : 1;
    localparam logic [HalfW-1:0]  HalfLast    = HalfW'(SckHalf - 1);

    seq_state_e           r_state;
    logic [DataWidth-1:0] r_shadow [NumChannels];
    logic [NumChannels-1:0] r_pending;
    logic [ChanW-1:0]     r_rr;
    logic [HalfW-1:0]     r_cnt;
    logic [SettleW-1:0]   r_settle;
    logic                 r_ldac;
    logic                 r_err;

    logic [ChanW-1:0]     w_sel;
    logic                 w_any;
    logic [DataWidth-1:0] w_sel_data;
    logic [11:0]          w_data12;
    logic [15:0]          w_frame;
    logic                 w_start;
    logic                 w_done;
    logic                 w_gap_end;

    // First pending channel at or after r_rr, wrapping.
    always_comb begin
        logic [NumChannels-1:0] pend_rot;
        int unsigned            c;
        w_sel    = '0;
        w_any    = 1'b0;
        pend_rot = '0;
        c        = 0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            c        = (32'(r_rr) + i) % NumChannels;
            pend_rot = r_pending >> c;
            if (!w_any && pend_rot[0]) begin
                w_any = 1'b1;
                w_sel = ChanW'(c);
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int unsigned k = 0; k < NumChannels; k++) begin
            if (32'(w_sel) == k) begin
                w_sel_data = r_shadow[k];
            end
        end
        w_data12 = 12'(w_sel_data) << (12 - DataWidth);
        w_frame  = {w_sel[0], FrameHdr, w_data12};
    end

    assign w_gap_end = (r_state == StGap) && (r_cnt == HalfLast);
    assign w_start   = w_any && ((r_state == StIdle) || (w_gap_end && sync_mode));

    always_ff @(posedge clk_50MHZ or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_pending <= '0;
            r_rr      <= '0;
            r_cnt     <= '0;
            r_settle  <= '0;
            r_ldac    <= 1'b1;
            r_err     <= 1'b0;
            for (int unsigned k = 0; k < NumChannels; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            // A write in the dispatch cycle wins over the pending clear.
            for (int unsigned k = 0; k < NumChannels; k++) begin
                if (wr_en && (32'(wr_chan) == k)) begin
                    r_shadow[k]  <= wr_data;
                    r_pending[k] <= 1'b1;
                end else if (w_start && (32'(w_sel) == k)) begin
                    r_pending[k] <= 1'b0;
                end
            end
            if (wr_en && (32'(wr_chan) >= NumChannels)) begin
                r_err <= 1'b1;
            end
            if (w_start) begin
                r_rr <= (32'(w_sel) == NumChannels - 1) ? '0 : w_sel + ChanW'(1);
            end

            case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_state <= StLoad;
                    end
                end
                StLoad: r_state <= StShift;
                StShift: begin
                    if (w_done) begin
                        r_cnt   <= '0;
                        r_state <= StGap;
                    end
                end
                StGap: begin
                    if (r_cnt == HalfLast) begin
                        r_cnt <= '0;
                        if (sync_mode && w_any) begin
                            r_state <= StLoad;
                        end else begin
                            r_ldac  <= 1'b0;
                            r_state <= StLdac;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StLdac: begin
                    if (r_cnt == HalfLast) begin
                        r_cnt    <= '0;
                        r_ldac   <= 1'b1;
                        r_settle <= '0;
                        r_state  <= (DelayClocks == 0) ? StIdle : StSettle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StSettle: begin
                    if (r_settle == SettleLast) begin
                        r_state <= StIdle;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    dac_spi_shifter #(
        .SckHalf (SckHalf)
    ) u_shifter (
        .i_clk   (clk_50MHZ),
        .i_rst_n (reset_n),
        .i_start (w_start),
        .i_frame (w_frame),
        .o_done  (w_done),
        .o_csn   (dac_csn),
        .o_sck   (dac_sck),
        .o_sdi   (dac_sdi)
    );

    assign busy     = (|r_pending) || (r_state != StIdle);
    assign settled  = ~busy;
    assign wr_err   = r_err;
    assign dac_ldac = r_ldac;

endmodule

// File: tb/tb_mercury2_dac_sequencer.sv
// Directed bench for mercury2_dac_sequencer: decodes the serial frames off the pins and
// checks timing, ordering, sync mode, in-flight rewrites, illegal channels and reset abort.
module tb_mercury2_dac_sequencer;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic       wr_chan;
    logic [9:0] wr_data;
    logic       sync_mode;
    logic       busy, settled, wr_err, dac_csn, dac_sdi, dac_ldac, dac_sck;

    logic       wr_en_b;
    logic       wr_chan_b;
    logic       busy_b, settled_b, wr_err_b, csn_b, sdi_b, ldac_b, sck_b;

    int vectors = 0;
    int fails   = 0;

    mercury2_dac_sequencer u_dut (
        .clk_50MHZ (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_chan   (wr_chan),
        .wr_data   (wr_data),
        .sync_mode (sync_mode),
        .busy      (busy),
        .settled   (settled),
        .wr_err    (wr_err),
        .dac_csn   (dac_csn),
        .dac_sdi   (dac_sdi),
        .dac_ldac  (dac_ldac),
        .dac_sck   (dac_sck)
    );

    // Single-channel instance: the only way to present an out-of-range channel.
    mercury2_dac_sequencer #(
        .NumChannels (1)
    ) u_one (
        .clk_50MHZ (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en_b),
        .wr_chan   (wr_chan_b),
        .wr_data   (wr_data),
        .sync_mode (sync_mode),
        .busy      (busy_b),
        .settled   (settled_b),
        .wr_err    (wr_err_b),
        .dac_csn   (csn_b),
        .dac_sdi   (sdi_b),
        .dac_ldac  (ldac_b),
        .dac_sck   (sck_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin monitors.
    int          sck_rises = 0, sck_hi = 0, ldac_pulses = 0, ldac_low = 0;
    int          csn_lo_run = 0, csn_hi_run = 0, last_lo = 0, last_gap = 0, settle_run = 0;
    int          nbits = 0;
    logic [15:0] sh = '0;
    logic [15:0] frames[$];

    always @(posedge dac_sck) begin
        sck_rises++;
        if (!dac_csn) begin
            sh = {sh[14:0], dac_sdi};
            nbits++;
        end
    end
    always @(negedge dac_csn) nbits = 0;
    always @(posedge dac_csn) if (nbits == 16) frames.push_back(sh);
    always @(negedge dac_ldac) ldac_pulses++;

    always @(negedge clk) begin
        if (!dac_ldac) ldac_low++;
        if (dac_sck) sck_hi++;
        if (!dac_csn) begin
            csn_lo_run++;
            if (csn_hi_run > 0) last_gap = csn_hi_run;
            csn_hi_run = 0;
        end else begin
            csn_hi_run++;
            if (csn_lo_run > 0) last_lo = csn_lo_run;
            csn_lo_run = 0;
        end
        if (!dac_ldac) settle_run = 0;
        else if (busy && dac_csn) settle_run++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic dac_write(input logic chan, input logic [9:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_chan = chan;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    int fb, sb, hb, lpb, llb;

    task automatic snap();
        fb  = frames.size();
        sb  = sck_rises;
        hb  = sck_hi;
        lpb = ldac_pulses;
        llb = ldac_low;
    endtask

    function automatic logic [31:0] frame_at(input int idx);
        if (idx < frames.size()) return 32'(frames[idx]);
        return 32'hDEAD_BEEF;
    endfunction

    initial begin
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_chan   = 1'b0;
        wr_data   = '0;
        sync_mode = 1'b0;
        wr_en_b   = 1'b0;
        wr_chan_b = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_csn", 32'(dac_csn), 32'd1);
        check("rst_sck", 32'(dac_sck), 32'd0);
        check("rst_sdi", 32'(dac_sdi), 32'd0);
        check("rst_ldac", 32'(dac_ldac), 32'd1);
        check("rst_wr_err", 32'(wr_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_settled", 32'(settled), 32'd1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write, ch0 = 0x2AB.
        snap();
        dac_write(1'b0, 10'h2AB);
        check("a_busy_after_write", 32'(busy), 32'd1);
        wait_idle("a_idle", 1500);
        check("a_nframes", 32'(frames.size() - fb), 32'd1);
        check("a_frame", frame_at(fb), 32'h3AAC);
        check("a_sck_rises", 32'(sck_rises - sb), 32'd16);
        check("a_sck_hi_cycles", 32'(sck_hi - hb), 32'd32);
        check("a_csn_low_cycles", 32'(last_lo), 32'd66);
        check("a_ldac_pulses", 32'(ldac_pulses - lpb), 32'd1);
        check("a_ldac_low_cycles", 32'(ldac_low - llb), 32'd2);
        check("a_settle_cycles", 32'(settle_run), 32'd225);
        check("a_settled", 32'(settled), 32'd1);

        // Two channels, per-frame LDAC.
        snap();
        dac_write(1'b0, 10'h155);
        dac_write(1'b1, 10'h3FF);
        wait_idle("b_idle", 2000);
        check("b_nframes", 32'(frames.size() - fb), 32'd2);
        check("b_frame0", frame_at(fb), 32'h3554);
        check("b_frame1", frame_at(fb + 1), 32'hBFFC);
        check("b_ldac_pulses", 32'(ldac_pulses - lpb), 32'd2);
        check("b_ldac_low_cycles", 32'(ldac_low - llb), 32'd4);
        check("b_csn_gap", 32'(last_gap), 32'd230);

        // Same writes, simultaneous update.
        sync_mode = 1'b1;
        snap();
        dac_write(1'b0, 10'h155);
        dac_write(1'b1, 10'h3FF);
        wait_idle("c_idle", 2000);
        sync_mode = 1'b0;
        check("c_nframes", 32'(frames.size() - fb), 32'd2);
        check("c_frame0", frame_at(fb), 32'h3554);
        check("c_frame1", frame_at(fb + 1), 32'hBFFC);
        check("c_csn_gap", 32'(last_gap), 32'd2);
        check("c_ldac_pulses", 32'(ldac_pulses - lpb), 32'd1);
        check("c_ldac_low_cycles", 32'(ldac_low - llb), 32'd2);
        check("c_settle_cycles", 32'(settle_run), 32'd225);

        // Rewrite of the channel that is mid-shift.
        snap();
        dac_write(1'b1, 10'h200);
        repeat (10) @(negedge clk);
        check("d_csn_low_mid", 32'(dac_csn), 32'd0);
        dac_write(1'b1, 10'h100);
        wait_idle("d_idle", 2000);
        check("d_nframes", 32'(frames.size() - fb), 32'd2);
        check("d_frame0", frame_at(fb), 32'hB800);
        check("d_frame1", frame_at(fb + 1), 32'hB400);
        check("d_ldac_pulses", 32'(ldac_pulses - lpb), 32'd2);

        // Illegal channel on the single-channel instance.
        check("e_err_before", 32'(wr_err_b), 32'd0);
        @(negedge clk);
        wr_en_b   = 1'b1;
        wr_chan_b = 1'b1;
        @(negedge clk);
        wr_en_b   = 1'b0;
        check("e_err_set", 32'(wr_err_b), 32'd1);
        repeat (5) @(negedge clk);
        check("e_err_sticky", 32'(wr_err_b), 32'd1);
        check("e_busy", 32'(busy_b), 32'd0);
        check("e_csn", 32'(csn_b), 32'd1);
        check("e_dut_err", 32'(wr_err), 32'd0);

        // Reset at the 8th sck rising edge.
        snap();
        dac_write(1'b0, 10'h123);
        for (int n = 0; n < 300 && (sck_rises - sb) < 8; n++) begin
            @(posedge clk);
            #1;
        end
        check("f_sck_rises", 32'(sck_rises - sb), 32'd8);
        reset_n = 1'b0;
        #1;
        check("f_csn", 32'(dac_csn), 32'd1);
        check("f_ldac", 32'(dac_ldac), 32'd1);
        check("f_sck", 32'(dac_sck), 32'd0);
        check("f_busy", 32'(busy), 32'd0);
        check("f_err_b_cleared", 32'(wr_err_b), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        check("f_no_ldac", 32'(ldac_pulses - lpb), 32'd0);
        check("f_no_frame", 32'(frames.size() - fb), 32'd0);
        check("f_idle_csn", 32'(dac_csn), 32'd1);
        check("f_idle_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
